// File: rtl/instr_loader.sv
// Boot-time instruction loader: parses a framed byte stream into a 32 x 14-bit
// instruction store and holds the core in reset until a complete program is loaded.
// Optional trailing XOR checksum: define INSTR_LOADER_CHKSUM_EN.
module instr_loader #(
  parameter int         DEPTH = 32,
  parameter logic [7:0] HDR   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic [4:0]  pc,
  output logic [13:0] instraction,
  output logic        core_rst,
  output logic        load_done,
  output logic        load_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CNT  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_WR   = 3'd4,
    S_CHK  = 3'd5,
    S_ERR  = 3'd6,
    S_RUN  = 3'd7
  } state_t;

  state_t           state_r;
  logic [13:0]      mem_r [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [5:0]       n_r;
  logic [4:0]       idx_r;
  logic [5:0]       hi_r;
  logic [7:0]       lo_r;
  logic             rx_ready_r;
  logic             core_rst_r;
  logic             load_done_r;
  logic             load_err_r;

  logic             xfer_s;
  logic             is_hdr_s;
  logic             cnt_ok_s;
  logic             last_word_s;

`ifdef INSTR_LOADER_CHKSUM_EN
  logic [7:0]       csum_r;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction
`endif

  // Byte-level decode shared by all states
  always_comb begin
    xfer_s      = rx_valid & rx_ready_r;
    is_hdr_s    = (rx_data == HDR);
    cnt_ok_s    = (rx_data != 8'd0) && (rx_data <= 8'd32);
    last_word_s = ({1'b0, idx_r} == (n_r - 6'd1));
  end

  // Unloaded or invalidated addresses read as NOP (all zero)
  always_comb begin
    if (valid_r[pc]) begin
      instraction = mem_r[pc];
    end else begin
      instraction = 14'h0000;
    end
  end

  // Instruction store is deliberately not reset; valid_r gates every read
  always_ff @(posedge clk) begin
    if (rst && (state_r == S_WR)) begin
      mem_r[idx_r] <= {hi_r, lo_r};
    end
  end

  // Frame parser with registered handshake and core-control outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= S_IDLE;
      valid_r     <= {DEPTH{1'b0}};
      n_r         <= 6'd0;
      idx_r       <= 5'd0;
      hi_r        <= 6'd0;
      lo_r        <= 8'd0;
      rx_ready_r  <= 1'b1;
      core_rst_r  <= 1'b0;
      load_done_r <= 1'b0;
      load_err_r  <= 1'b0;
`ifdef INSTR_LOADER_CHKSUM_EN
      csum_r      <= 8'd0;
`endif
    end else begin
      case (state_r)
        S_IDLE: begin
          if (xfer_s && is_hdr_s) begin
            state_r    <= S_CNT;
            valid_r    <= {DEPTH{1'b0}};
            load_err_r <= 1'b0;
          end
        end
        S_CNT: begin
          if (xfer_s) begin
            if (cnt_ok_s) begin
              n_r     <= rx_data[5:0];
              idx_r   <= 5'd0;
              state_r <= S_HI;
`ifdef INSTR_LOADER_CHKSUM_EN
              csum_r  <= 8'd0;
`endif
            end else begin
              state_r    <= S_ERR;
              rx_ready_r <= 1'b0;
            end
          end
        end
        S_HI: begin
          if (xfer_s) begin
            if (rx_data[7:6] != 2'b00) begin
              state_r    <= S_ERR;
              rx_ready_r <= 1'b0;
            end else begin
              hi_r    <= rx_data[5:0];
              state_r <= S_LO;
`ifdef INSTR_LOADER_CHKSUM_EN
              csum_r  <= csum_fold(csum_r, rx_data);
`endif
            end
          end
        end
        S_LO: begin
          if (xfer_s) begin
            lo_r       <= rx_data;
            state_r    <= S_WR;
            rx_ready_r <= 1'b0;
`ifdef INSTR_LOADER_CHKSUM_EN
            csum_r     <= csum_fold(csum_r, rx_data);
`endif
          end
        end
        S_WR: begin
          valid_r[idx_r] <= 1'b1;
          rx_ready_r     <= 1'b1;
          if (last_word_s) begin
`ifdef INSTR_LOADER_CHKSUM_EN
            state_r     <= S_CHK;
`else
            state_r     <= S_RUN;
            core_rst_r  <= 1'b1;
            load_done_r <= 1'b1;
`endif
          end else begin
            idx_r   <= idx_r + 5'd1;
            state_r <= S_HI;
          end
        end
`ifdef INSTR_LOADER_CHKSUM_EN
        S_CHK: begin
          if (xfer_s) begin
            if (rx_data == csum_r) begin
              state_r     <= S_RUN;
              core_rst_r  <= 1'b1;
              load_done_r <= 1'b1;
            end else begin
              state_r    <= S_ERR;
              rx_ready_r <= 1'b0;
            end
          end
        end
`endif
        S_ERR: begin
          load_err_r <= 1'b1;
          valid_r    <= {DEPTH{1'b0}};
          rx_ready_r <= 1'b1;
          state_r    <= S_IDLE;
        end
        S_RUN: begin
          if (xfer_s && is_hdr_s) begin
            state_r     <= S_CNT;
            valid_r     <= {DEPTH{1'b0}};
            load_err_r  <= 1'b0;
            core_rst_r  <= 1'b0;
            load_done_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          valid_r     <= {DEPTH{1'b0}};
          rx_ready_r  <= 1'b1;
          core_rst_r  <= 1'b0;
          load_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready  = rx_ready_r;
  assign core_rst  = core_rst_r;
  assign load_done = load_done_r;
  assign load_err  = load_err_r;

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time instruction loader that sits directly upstream of `core`. It receives a framed byte stream over a valid/ready handshake and writes 14-bit instructions into a 32-entry instruction memory. It serves `instraction = mem[pc]` combinationally to the core and holds the core in reset until a complete, valid program has been loaded.

## Interface
Parameters:
- `DEPTH`, 32: instruction words; the address width is 5 bits and is fixed for this core.
- `HDR`, 8'hA5: frame header byte.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  synchronous, active-low reset.
- `rx_valid`  in  1  byte-stream valid.
- `rx_data`  in  8  byte-stream data.
- `rx_ready`  out  1  loader accepts the byte. A transfer occurs when `rx_valid & rx_ready` at a rising edge.
- `pc`  in  5  read address from the core.
- `instraction`  out  14  `mem[pc]` if `valid[pc]`, else 14'h0000. Combinational.
- `core_rst`  out  1  active-low reset to the core; low whenever no verified program is present.
- `load_done`  out  1  high while in RUN.
- `load_err`  out  1  sticky error flag; cleared by the next HDR byte or by `rst`.

## Operation
Frame format: `HDR`, then `N` (1..32), then N words sent high byte first, then the checksum byte if configured. The high byte carries `{2'b00, instr[13:8]}`. The low byte carries `instr[7:0]`.

States and transitions:
- **IDLE**
  - byte == HDR → CNT; clear the `valid` vector and `load_err`.
  - Any other byte is discarded.
- **CNT**
  - byte in 1..32 → HI; latch N; set `idx` = 0 and `csum` = 0.
  - byte == 0 or byte > 32 → ERR.
- **HI**
  - byte[7:6] != 0 → ERR.
  - Otherwise latch byte[5:0] and XOR the byte into `csum`; → LO.
- **LO**
  - Latch the byte and XOR it into `csum`; → WR.
- **WR** (one cycle, `rx_ready` = 0)
  - Write `mem[idx]`, set `valid[idx]`.
  - If `idx == N-1` → CHK, or → RUN when the checksum is compiled out.
  - Otherwise increment `idx` and → HI.
- **CHK**
  - byte == `csum` → RUN.
  - Otherwise → ERR.
- **ERR** (one cycle, `rx_ready` = 0)
  - Set `load_err`, clear the `valid` vector; → IDLE.
- **RUN**
  - byte == HDR → CNT; clear `valid` and `load_err`; `core_rst` drops.
  - Other bytes are discarded.

Behaviour details:
- `rx_ready` = 1 in every state except WR and ERR.
- `core_rst` and `load_done` are registered. Both are 1 only in RUN.
- Unloaded addresses (`pc` ≥ N) read as 0, which the core treats as NOP.
- The memory array itself is not reset; only the `valid` vector is.

## Timing
- Reset values: `rx_ready` = 1, `core_rst` = 0, `load_done` = 0, `load_err` = 0, state IDLE, `valid` = 0.
- Reset asserted mid-frame aborts the frame. The next frame must begin with HDR.
- Latency: `core_rst` and `load_done` go high on the edge that accepts the checksum byte (or the edge that completes the last WR when the checksum is compiled out). The core runs from the following cycle.
- `core_rst` falls on the edge that accepts HDR in RUN. The core is reset from the next cycle.
- `load_err` rises on the edge leaving ERR. It stays high through IDLE until the next HDR.
- Per word: 2 accepted bytes plus 1 WR stall cycle, so at least 3 cycles per word.
- Write-during-read: a WR to the address currently selected by `pc` is visible on `instraction` the cycle after the edge. The core is in reset during loading in any case.
- A checksum failure leaves every address reading 0.

## Configuration
- `INSTR_LOADER_CHKSUM_EN` defined:
  - A trailing checksum byte is required: the XOR of all 2N data bytes.
  - Mismatch → ERR.
- Not defined:
  - There is no CHK state; WR of the last word → RUN directly.
  - `csum` logic is removed.
  - A byte following the last word is treated as a RUN-state byte.

## Test plan
- **Basic load.** After reset, send A5, 02, 00, 11, 3F, FF, checksum 0xD1.
  - Expect `mem[0]` = 14'h0011 and `mem[1]` = 14'h3FFF.
  - Expect `core_rst` = 1 and `load_done` = 1.
  - `pc` = 0/1/5 reads 0011/3FFF/0000.
- **Bad checksum.** Same frame with checksum 0x00.
  - Expect `load_err` = 1 and `core_rst` = 0.
  - All `pc` values read 0.
  - `rx_ready` is low for exactly 1 cycle (ERR).
- **Illegal count and illegal high byte.**
  - Count 0x21 → ERR.
  - Count 0x00 → ERR.
  - High byte 0x40 → ERR.
  - `valid` is cleared in each case.
- **Handshake.**
  - `rx_ready` = 0 exactly one cycle after each LO byte.
  - A byte held with `rx_valid` = 1 during WR is accepted on the next cycle, not duplicated.
- **Reload and reset.**
  - HDR received in RUN drops `core_rst` on the next cycle; the old program reads 0 until rewritten.
  - `rst` = 0 mid-frame returns the loader to IDLE with `core_rst` = 0.
  - Remaining bytes of the aborted frame, without a new HDR, are ignored.
- **Checksum compiled out.** Build without `INSTR_LOADER_CHKSUM_EN` and send A5, 01, 00, 05.
  - Expect RUN after WR.
  - Expect `mem[0]` = 14'h0005.
